// File: rtl/sm_twos_conv_pipe.sv
// Streaming sign-magnitude <-> two's complement converter with a DEPTH-stage valid/ready pipeline.
// Optional flagged-transfer counter built when SMTC_ERRCNT_EN is defined; otherwise err_cnt reads 0.
module sm_twos_conv_pipe #(
  parameter int WIDTH = 8,  // 2..32, includes sign bit
  parameter int DEPTH = 2   // 1..4 register stages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_negz,
  output logic             out_ovf,
  output logic [15:0]      err_cnt
);

  typedef struct packed {
    logic             valid;
    logic             negz;
    logic             ovf;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           conv;
  stage_t           last;
  logic [DEPTH-1:0] vld;
  logic [DEPTH:0]   ld;
  logic [WIDTH-1:0] neg;

  assign neg = -in_data;

  // The whole conversion happens here; later stages only carry the result.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    conv       = '0;
    conv.valid = in_valid;
    if (!in_data[WIDTH-1]) begin
      conv.data = in_data;
    end else if (!in_mode) begin
      conv.data = ~{1'b0, in_data[WIDTH-2:0]} + WIDTH'(1);
      conv.negz = (in_data[WIDTH-2:0] == '0);
    end else if (in_data[WIDTH-2:0] == '0) begin
      conv.data = '1;
      conv.ovf  = 1'b1;
    end else begin
      conv.data = {1'b1, neg[WIDTH-2:0]};
    end
  end

  // ld[k]: stage k captures this edge. ld[DEPTH] stands for the downstream sink.
  always_comb begin
    ld        = '0;
    ld[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ld[k] = !vld[k] || ld[k+1];
    end
  end

  assign in_ready = ld[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    stage_t src;
    stage_t q;

    if (k == 0) begin : g_head
      assign src = conv;
    end else begin : g_body
      assign src = g_stage[k-1].q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: payload registers are reset as well, so out_data and flags read 0 after reset.
      if (!rst_n) begin
        q <= '0;
      end else if (ld[k]) begin
        // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
        q.valid <= src.valid;
        // Payload only moves with a real word, so out_data holds while idle.
        if (src.valid) begin
          q.negz <= src.negz;
          q.ovf  <= src.ovf;
          q.data <= src.data;
        end
      end
    end

    assign vld[k] = q.valid;

    if (k == DEPTH - 1) begin : g_tail
      assign last = q;
    end
  end

  assign out_valid = last.valid;
  assign out_data  = last.data;
  assign out_negz  = last.negz;
  assign out_ovf   = last.ovf;

`ifdef SMTC_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (out_valid && out_ready && (out_negz || out_ovf) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sm_twos_conv_pipe.sv
// Randomised/exhaustive bench for sm_twos_conv_pipe against an arithmetic reference model.
// Define SMTC_ERRCNT_EN for both bench and RTL to exercise the error counter.
module tb_sm_twos_conv_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             negz;
    logic             ovf;
    int               cyc;
  } exp_t;

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_negz;
  logic             out_ovf;
  logic [15:0]      err_cnt;

  int checks = 0;
  int passed = 0;

  sm_twos_conv_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_negz(out_negz), .out_ovf(out_ovf), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference: interpret the input as a signed integer, re-encode it in the target format.
  function automatic exp_t ref_model(input logic mode, input logic [WIDTH-1:0] x);
    longint half = longint'(1) << (WIDTH - 1);
    longint full = half * 2;
    longint u    = longint'(x);
    longint v;
    longint mag;
    exp_t   e    = '0;
    if (!mode) begin
      mag    = u % half;
      v      = (u >= half) ? -mag : mag;
      e.negz = (u >= half) && (mag == 0);
      e.data = WIDTH'((v + full) % full);
    end else begin
      v = (u >= half) ? u - full : u;
      if (v == -half) begin
        e.ovf  = 1'b1;
        e.data = WIDTH'(full - 1);
      end else if (v < 0) begin
        e.data = WIDTH'(half - v);
      end else begin
        e.data = WIDTH'(v);
      end
    end
    return e;
  endfunction

  task automatic send_one(input logic mode, input logic [WIDTH-1:0] d,
                          output logic [WIDTH+1:0] obs, output bit got);
    got = 1'b0;
    obs = 'x;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = mode;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH + 4 && !got; i++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        obs = {out_data, out_negz, out_ovf};
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_negz, out_ovf, err_cnt} !== '0)
      $display("FAIL reset_state: got valid=%b data=%h negz=%b ovf=%b err=%h, want all zero",
               out_valid, out_data, out_negz, out_ovf, err_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_corners();
    logic [WIDTH-1:0] mag5  = WIDTH'(5 % (1 << (WIDTH - 1)));
    logic [WIDTH-1:0] sm5   = MIN_V | mag5;
    logic [WIDTH-1:0] tc5   = -mag5;
    logic             m_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] d_tab [6];
    logic [WIDTH+1:0] e_tab [6];
    logic [WIDTH+1:0] obs;
    bit               got;
    d_tab = '{sm5, tc5, MIN_V, MIN_V, MAX_V, MAX_V};
    e_tab = '{{tc5, 2'b00}, {sm5, 2'b00}, {{WIDTH{1'b0}}, 2'b10},
              {{WIDTH{1'b1}}, 2'b01}, {MAX_V, 2'b00}, {MAX_V, 2'b00}};
    for (int i = 0; i < 6; i++) begin
      send_one(m_tab[i], d_tab[i], obs, got);
      checks++;
      if (!got || obs !== e_tab[i])
        $display("FAIL corner_%0d mode=%b in=%h: got valid=%b {data,negz,ovf}=%h want %h",
                 i, m_tab[i], d_tab[i], got, obs, e_tab[i]);
      else passed++;
    end
  endtask

  // mode_sel: 0 = SM->TC, 1 = TC->SM, 2 = alternate per word.
  task automatic run_stream(input string name, input int n, input int mode_sel,
                            input bit seq_data, input int rdy_pct);
    exp_t             q[$];
    exp_t             e;
    int               sent = 0;
    int               cyc = 0;
    int               limit = n * 8 + 200;
    bit               took = 1'b0;
    bit               stall_pend = 1'b0;
    logic [WIDTH+1:0] stall_word = '0;
    while ((sent < n || q.size() != 0) && cyc < limit) begin
      @(negedge clk);
      if (took) in_valid = 1'b0;
      if (!in_valid && sent < n) begin
        in_valid = 1'b1;
        in_data  = seq_data ? WIDTH'(sent) : WIDTH'($urandom);
        in_mode  = (mode_sel == 2) ? sent[0] : mode_sel[0];
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (stall_pend) begin
        checks++;
        if (!out_valid || {out_data, out_negz, out_ovf} !== stall_word)
          $display("FAIL %s stall_hold cyc %0d: got valid=%b word=%h want valid=1 word=%h",
                   name, cyc, out_valid, {out_data, out_negz, out_ovf}, stall_word);
        else passed++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL %s extra_word cyc %0d: got data=%h want no output", name, cyc, out_data);
        end else begin
          e = q.pop_front();
          if ({out_data, out_negz, out_ovf} !== {e.data, e.negz, e.ovf})
            $display("FAIL %s data cyc %0d: got data=%h negz=%b ovf=%b want data=%h negz=%b ovf=%b",
                     name, cyc, out_data, out_negz, out_ovf, e.data, e.negz, e.ovf);
          else passed++;
          if (rdy_pct >= 100) begin
            checks++;
            if (cyc - e.cyc != DEPTH)
              $display("FAIL %s latency: got %0d want %0d", name, cyc - e.cyc, DEPTH);
            else passed++;
          end
        end
      end
      stall_pend = out_valid && !out_ready;
      stall_word = {out_data, out_negz, out_ovf};
      took = in_valid && in_ready;
      if (took) begin
        e     = ref_model(in_mode, in_data);
        e.cyc = cyc;
        q.push_back(e);
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= limit) begin
      checks++;
      $display("FAIL %s timeout: got %0d sent %0d pending want all %0d drained", name, sent, q.size(), n);
    end
  endtask

  task automatic test_reset_flush();
    logic [WIDTH+1:0] obs;
    bit               got;
    bit               leaked = 1'b0;
    exp_t             e = ref_model(1'b0, WIDTH'(3 % (1 << (WIDTH - 1))));
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      in_mode  = i[0];
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", out_valid);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_negz, out_ovf, err_cnt} !== '0)
      $display("FAIL flush_async: got valid=%b data=%h negz=%b ovf=%b err=%h want all zero",
               out_valid, out_data, out_negz, out_ovf, err_cnt);
    else passed++;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) leaked = 1'b1;
    end
    checks++;
    if (leaked) $display("FAIL flush_leak: got stale out_valid=1 want 0");
    else passed++;
    send_one(1'b0, WIDTH'(3 % (1 << (WIDTH - 1))), obs, got);
    checks++;
    if (!got || obs !== {e.data, e.negz, e.ovf})
      $display("FAIL flush_next: got valid=%b word=%h want %h", got, obs, {e.data, e.negz, e.ovf});
    else passed++;
  endtask

  task automatic test_err_cnt();
    logic [WIDTH+1:0] obs;
    bit               got;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send_one(i >= 3, MIN_V, obs, got);
    @(negedge clk);
    #1;
`ifdef SMTC_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd5) $display("FAIL err_cnt_five: got %0d want 5", err_cnt);
    else passed++;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = MIN_V;
    for (int i = 0; i < 70000; i++) begin
      in_mode = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (DEPTH + 2) @(negedge clk);
    #1;
    checks++;
    if (err_cnt !== 16'hFFFF) $display("FAIL err_cnt_sat: got %h want ffff", err_cnt);
    else passed++;
`else
    checks++;
    if (err_cnt !== 16'h0000) $display("FAIL err_cnt_tied: got %h want 0000", err_cnt);
    else passed++;
`endif
  endtask

  initial begin
    int n_exh;
    n_exh = (WIDTH <= 10) ? (1 << WIDTH) : 1024;
    test_reset();
    test_corners();
    run_stream("exh_sm2tc", n_exh, 0, WIDTH <= 10, 100);
    run_stream("exh_tc2sm", n_exh, 1, WIDTH <= 10, 100);
    run_stream("rand_bp", 1000, 2, 1'b0, 50);
    test_reset_flush();
    test_err_cnt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
